// File: rtl/rvh_mmu_ptw.sv
// Sv39 page-table walker: one walk in flight, up to three PTE reads,
// single-cycle registered response pulse with leaf PTE, level and fault status.
module rvh_mmu_ptw #(
    parameter int unsigned VPN_WIDTH      = 27,
    parameter int unsigned PPN_WIDTH      = 44,
    parameter int unsigned PADDR_WIDTH    = 56,
    parameter int unsigned ASID_WIDTH     = 16,
    parameter int unsigned TRANS_ID_WIDTH = 3,
    parameter int unsigned PTE_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      walk_req_vld_i,
    output logic                      walk_req_rdy_o,
    input  logic [TRANS_ID_WIDTH-1:0] walk_req_trans_id_i,
    input  logic [ASID_WIDTH-1:0]     walk_req_asid_i,
    input  logic [VPN_WIDTH-1:0]      walk_req_vpn_i,
    input  logic [1:0]                walk_req_access_type_i,
    input  logic [PPN_WIDTH-1:0]      satp_ppn_i,
    output logic                      ptw_mem_req_vld_o,
    output logic [PADDR_WIDTH-1:0]    ptw_mem_req_addr_o,
    input  logic                      ptw_mem_req_rdy_i,
    input  logic                      ptw_mem_resp_vld_i,
    input  logic [PTE_WIDTH-1:0]      ptw_mem_resp_data_i,
    input  logic                      ptw_mem_resp_err_i,
    output logic                      walk_resp_vld_o,
    output logic [TRANS_ID_WIDTH-1:0] walk_resp_trans_id_o,
    output logic [ASID_WIDTH-1:0]     walk_resp_asid_o,
    output logic [VPN_WIDTH-1:0]      walk_resp_vpn_o,
    output logic [PTE_WIDTH-1:0]      walk_resp_pte_o,
    output logic [1:0]                walk_resp_level_o,
    output logic                      walk_resp_page_fault_o,
    output logic                      walk_resp_access_fault_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Walk context captured at accept
    logic [TRANS_ID_WIDTH-1:0] trans_id, trans_id_nxt;
    logic [ASID_WIDTH-1:0]     asid, asid_nxt;
    logic [VPN_WIDTH-1:0]      vpn, vpn_nxt;
    logic [1:0]                access_type, access_type_nxt;
    logic [PPN_WIDTH-1:0]      table_ppn, table_ppn_nxt;
    logic [1:0]                level, level_nxt;

    // Registered outputs
    logic                      req_rdy, req_rdy_nxt;
    logic                      busy, busy_nxt;
    logic                      mem_vld, mem_vld_nxt;
    logic [PADDR_WIDTH-1:0]    mem_addr, mem_addr_nxt;
    logic                      resp_vld, resp_vld_nxt;
    logic [TRANS_ID_WIDTH-1:0] resp_trans_id, resp_trans_id_nxt;
    logic [ASID_WIDTH-1:0]     resp_asid, resp_asid_nxt;
    logic [VPN_WIDTH-1:0]      resp_vpn, resp_vpn_nxt;
    logic [PTE_WIDTH-1:0]      resp_pte, resp_pte_nxt;
    logic [1:0]                resp_level, resp_level_nxt;
    logic                      resp_pf, resp_pf_nxt;
    logic                      resp_af, resp_af_nxt;

    // PTE decode of the incoming read data
    logic pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
    logic pte_invalid, pte_leaf, leaf_fault;
    logic [8:0] vpn_idx;

    // Classify the returned PTE against the current level and access type
    always_comb begin
        pte_v = ptw_mem_resp_data_i[0];
        pte_r = ptw_mem_resp_data_i[1];
        pte_w = ptw_mem_resp_data_i[2];
        pte_x = ptw_mem_resp_data_i[3];
        pte_a = ptw_mem_resp_data_i[6];
        pte_d = ptw_mem_resp_data_i[7];
        pte_invalid = !pte_v || (!pte_r && pte_w) || (|ptw_mem_resp_data_i[63:54]);
        pte_leaf    = pte_r || pte_x;
        leaf_fault  = 1'b0;
        case (access_type)
            2'd0:    leaf_fault = !pte_r;
            2'd1:    leaf_fault = !pte_w || !pte_d;
            2'd2:    leaf_fault = !pte_x;
            default: leaf_fault = 1'b1;
        endcase
        if (!pte_a) leaf_fault = 1'b1;
        if (level == 2'd2 && (|ptw_mem_resp_data_i[27:10])) leaf_fault = 1'b1;
        if (level == 2'd1 && (|ptw_mem_resp_data_i[18:10])) leaf_fault = 1'b1;
    end

    // Next-state, walk context and registered-output values
    always_comb begin
        state_nxt         = state;
        trans_id_nxt      = trans_id;
        asid_nxt          = asid;
        vpn_nxt           = vpn;
        access_type_nxt   = access_type;
        table_ppn_nxt     = table_ppn;
        level_nxt         = level;
        resp_vld_nxt      = 1'b0;
        resp_trans_id_nxt = resp_trans_id;
        resp_asid_nxt     = resp_asid;
        resp_vpn_nxt      = resp_vpn;
        resp_pte_nxt      = resp_pte;
        resp_level_nxt    = resp_level;
        resp_pf_nxt       = resp_pf;
        resp_af_nxt       = resp_af;
        vpn_idx           = '0;

        case (state)
            IDLE: begin
                if (walk_req_vld_i) begin
                    trans_id_nxt    = walk_req_trans_id_i;
                    asid_nxt        = walk_req_asid_i;
                    vpn_nxt         = walk_req_vpn_i;
                    access_type_nxt = walk_req_access_type_i;
                    table_ppn_nxt   = satp_ppn_i;
                    level_nxt       = 2'd2;
                    state_nxt       = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (ptw_mem_req_rdy_i) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (ptw_mem_resp_vld_i) begin
                    if (!ptw_mem_resp_err_i && !pte_invalid && !pte_leaf && level != 2'd0) begin
                        table_ppn_nxt = ptw_mem_resp_data_i[53:10];
                        level_nxt     = level - 2'd1;
                        state_nxt     = MEM_REQ;
                    end else begin
                        // Any terminal outcome: fault priority is err > malformed > leaf checks
                        resp_vld_nxt      = 1'b1;
                        resp_trans_id_nxt = trans_id;
                        resp_asid_nxt     = asid;
                        resp_vpn_nxt      = vpn;
                        resp_pte_nxt      = ptw_mem_resp_data_i;
                        resp_level_nxt    = level;
                        resp_af_nxt       = ptw_mem_resp_err_i;
                        resp_pf_nxt       = !ptw_mem_resp_err_i &&
                                            (pte_invalid || !pte_leaf || leaf_fault);
                        state_nxt         = RESP;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        case (level_nxt)
            2'd2:    vpn_idx = vpn_nxt[26:18];
            2'd1:    vpn_idx = vpn_nxt[17:9];
            default: vpn_idx = vpn_nxt[8:0];
        endcase

        req_rdy_nxt  = (state_nxt == IDLE);
        busy_nxt     = (state_nxt != IDLE);
        mem_vld_nxt  = (state_nxt == MEM_REQ);
        mem_addr_nxt = mem_addr;
        if (state_nxt == MEM_REQ) begin
            mem_addr_nxt = PADDR_WIDTH'({table_ppn_nxt, 12'b0}) + PADDR_WIDTH'({vpn_idx, 3'b000});
        end
    end

    // State, context and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            trans_id      <= '0;
            asid          <= '0;
            vpn           <= '0;
            access_type   <= '0;
            table_ppn     <= '0;
            level         <= '0;
            req_rdy       <= 1'b1;
            busy          <= 1'b0;
            mem_vld       <= 1'b0;
            mem_addr      <= '0;
            resp_vld      <= 1'b0;
            resp_trans_id <= '0;
            resp_asid     <= '0;
            resp_vpn      <= '0;
            resp_pte      <= '0;
            resp_level    <= '0;
            resp_pf       <= 1'b0;
            resp_af       <= 1'b0;
        end else begin
            state         <= state_nxt;
            trans_id      <= trans_id_nxt;
            asid          <= asid_nxt;
            vpn           <= vpn_nxt;
            access_type   <= access_type_nxt;
            table_ppn     <= table_ppn_nxt;
            level         <= level_nxt;
            req_rdy       <= req_rdy_nxt;
            busy          <= busy_nxt;
            mem_vld       <= mem_vld_nxt;
            mem_addr      <= mem_addr_nxt;
            resp_vld      <= resp_vld_nxt;
            resp_trans_id <= resp_trans_id_nxt;
            resp_asid     <= resp_asid_nxt;
            resp_vpn      <= resp_vpn_nxt;
            resp_pte      <= resp_pte_nxt;
            resp_level    <= resp_level_nxt;
            resp_pf       <= resp_pf_nxt;
            resp_af       <= resp_af_nxt;
        end
    end

    assign walk_req_rdy_o           = req_rdy;
    assign busy_o                   = busy;
    assign ptw_mem_req_vld_o        = mem_vld;
    assign ptw_mem_req_addr_o       = mem_addr;
    assign walk_resp_vld_o          = resp_vld;
    assign walk_resp_trans_id_o     = resp_trans_id;
    assign walk_resp_asid_o         = resp_asid;
    assign walk_resp_vpn_o          = resp_vpn;
    assign walk_resp_pte_o          = resp_pte;
    assign walk_resp_level_o        = resp_level;
    assign walk_resp_page_fault_o   = resp_pf;
    assign walk_resp_access_fault_o = resp_af;

endmodule

// File: tb/tb_rvh_mmu_ptw.sv
// Randomized bench for the Sv39 walker with an on-the-fly page-table model.
module tb_rvh_mmu_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        walk_req_vld_i;
    logic        walk_req_rdy_o;
    logic [2:0]  walk_req_trans_id_i;
    logic [15:0] walk_req_asid_i;
    logic [26:0] walk_req_vpn_i;
    logic [1:0]  walk_req_access_type_i;
    logic [43:0] satp_ppn_i;
    logic        ptw_mem_req_vld_o;
    logic [55:0] ptw_mem_req_addr_o;
    logic        ptw_mem_req_rdy_i;
    logic        ptw_mem_resp_vld_i;
    logic [63:0] ptw_mem_resp_data_i;
    logic        ptw_mem_resp_err_i;
    logic        walk_resp_vld_o;
    logic [2:0]  walk_resp_trans_id_o;
    logic [15:0] walk_resp_asid_o;
    logic [26:0] walk_resp_vpn_o;
    logic [63:0] walk_resp_pte_o;
    logic [1:0]  walk_resp_level_o;
    logic        walk_resp_page_fault_o;
    logic        walk_resp_access_fault_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cycles = -1;
    logic [63:0] forced_pte[$];
    bit          forced_err[$];

    always #5 clk = ~clk;

    rvh_mmu_ptw #(
        .VPN_WIDTH(27), .PPN_WIDTH(44), .PADDR_WIDTH(56),
        .ASID_WIDTH(16), .TRANS_ID_WIDTH(3), .PTE_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst),
        .walk_req_vld_i(walk_req_vld_i), .walk_req_rdy_o(walk_req_rdy_o),
        .walk_req_trans_id_i(walk_req_trans_id_i), .walk_req_asid_i(walk_req_asid_i),
        .walk_req_vpn_i(walk_req_vpn_i), .walk_req_access_type_i(walk_req_access_type_i),
        .satp_ppn_i(satp_ppn_i),
        .ptw_mem_req_vld_o(ptw_mem_req_vld_o), .ptw_mem_req_addr_o(ptw_mem_req_addr_o),
        .ptw_mem_req_rdy_i(ptw_mem_req_rdy_i),
        .ptw_mem_resp_vld_i(ptw_mem_resp_vld_i), .ptw_mem_resp_data_i(ptw_mem_resp_data_i),
        .ptw_mem_resp_err_i(ptw_mem_resp_err_i),
        .walk_resp_vld_o(walk_resp_vld_o), .walk_resp_trans_id_o(walk_resp_trans_id_o),
        .walk_resp_asid_o(walk_resp_asid_o), .walk_resp_vpn_o(walk_resp_vpn_o),
        .walk_resp_pte_o(walk_resp_pte_o), .walk_resp_level_o(walk_resp_level_o),
        .walk_resp_page_fault_o(walk_resp_page_fault_o),
        .walk_resp_access_fault_o(walk_resp_access_fault_o),
        .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decision for one returned PTE, straight from the Sv39 rules
    function automatic void model_pte(input logic [63:0] p, input bit e, input int lvl,
                                      input logic [1:0] at, output bit done,
                                      output bit pf, output bit af);
        longint unsigned ppn;
        longint unsigned page;
        done = 1'b1; pf = 1'b0; af = 1'b0;
        ppn  = longint'(p[53:10]);
        page = 64'd1 << (9 * lvl);
        if (e) af = 1'b1;
        else if (!p[0] || (!p[1] && p[2]) || p[63:54] != 10'd0) pf = 1'b1;
        else if (p[1] || p[3]) begin
            if (at == 2'd0 && !p[1]) pf = 1'b1;
            if (at == 2'd1 && (!p[2] || !p[7])) pf = 1'b1;
            if (at == 2'd2 && !p[3]) pf = 1'b1;
            if (at == 2'd3) pf = 1'b1;
            if (!p[6]) pf = 1'b1;
            if (ppn % page != 0) pf = 1'b1;
        end else if (lvl == 0) pf = 1'b1;
        else done = 1'b0;
    endfunction

    function automatic logic [63:0] gen_pte(input int lvl);
        int k;
        logic [43:0] ppn;
        logic r, w, x, a, d;
        k   = $urandom_range(0, 99);
        ppn = 44'({$urandom(), $urandom()});
        if (k < 40) return {10'd0, ppn, 10'h001};
        if (k < 80) begin
            r = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1)); x = 1'($urandom_range(0, 1));
            if (!r && !x) r = 1'b1;
            a = ($urandom_range(0, 9) < 9); d = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) < 7) ppn = ppn & ~((44'd1 << (9 * lvl)) - 44'd1);
            return {10'd0, ppn, 2'b00, d, a, 2'b00, x, w, r, 1'b1};
        end
        if (k < 92) return {$urandom(), $urandom()};
        return {$urandom(), $urandom()} & ~64'd1;
    endfunction

    // Drive one walk end to end in lockstep with the DUT, checking each cycle
    task automatic run_walk(input logic [2:0] tid, input logic [15:0] asid, input logic [26:0] vpn,
                            input logic [1:0] at, input logic [43:0] satp,
                            input int exp_reqs, input int exp_pf, input int exp_af);
        int lvl;
        int nreq;
        int hold;
        logic [43:0] tbl;
        logic [63:0] pte;
        logic [55:0] exp_addr;
        logic [26:0] idx;
        bit err, done, pf, af;
        lvl = 2; tbl = satp; nreq = 0; done = 1'b0; pf = 1'b0; af = 1'b0; pte = '0;
        check("rdy_idle", walk_req_rdy_o, 1);
        walk_req_vld_i = 1'b1; walk_req_trans_id_i = tid; walk_req_asid_i = asid;
        walk_req_vpn_i = vpn; walk_req_access_type_i = at; satp_ppn_i = satp;
        @(negedge clk);
        walk_req_vld_i = 1'b0;
        satp_ppn_i = 44'({$urandom(), $urandom()});
        while (!done) begin
            idx = (vpn >> (9 * lvl)) & 27'h1ff;
            exp_addr = 56'(tbl) * 56'd4096 + 56'(idx) * 56'd8;
            check("mem_vld", ptw_mem_req_vld_o, 1);
            check("mem_addr", ptw_mem_req_addr_o, exp_addr);
            check("busy_walk", busy_o, 1);
            check("rdy_walk", walk_req_rdy_o, 0);
            hold = (hold_cycles >= 0) ? hold_cycles : $urandom_range(0, 3);
            repeat (hold) begin
                walk_req_vld_i = 1'($urandom_range(0, 1));
                walk_req_trans_id_i = 3'($urandom());
                ptw_mem_resp_vld_i = 1'($urandom_range(0, 1));
                ptw_mem_resp_data_i = {$urandom(), $urandom()};
                @(negedge clk);
                check("mem_vld_hold", ptw_mem_req_vld_o, 1);
                check("mem_addr_hold", ptw_mem_req_addr_o, exp_addr);
                check("rdy_hold", walk_req_rdy_o, 0);
            end
            ptw_mem_resp_vld_i = 1'b0;
            ptw_mem_req_rdy_i = 1'b1;
            @(negedge clk);
            ptw_mem_req_rdy_i = 1'b0;
            nreq++;
            repeat ($urandom_range(0, 3)) begin
                check("mem_vld_wait", ptw_mem_req_vld_o, 0);
                walk_req_vld_i = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            check("mem_vld_wait", ptw_mem_req_vld_o, 0);
            pte = (forced_pte.size() > 0) ? forced_pte.pop_front() : gen_pte(lvl);
            err = (forced_err.size() > 0) ? forced_err.pop_front() : ($urandom_range(0, 99) < 6);
            ptw_mem_resp_vld_i = 1'b1; ptw_mem_resp_data_i = pte; ptw_mem_resp_err_i = err;
            model_pte(pte, err, lvl, at, done, pf, af);
            @(negedge clk);
            ptw_mem_resp_vld_i = 1'b0; ptw_mem_resp_err_i = 1'b0;
            ptw_mem_resp_data_i = {$urandom(), $urandom()};
            if (!done) begin
                lvl--;
                tbl = pte[53:10];
            end
        end
        walk_req_vld_i = 1'b1;
        walk_req_trans_id_i = 3'($urandom());
        check("resp_vld", walk_resp_vld_o, 1);
        check("resp_tid", walk_resp_trans_id_o, tid);
        check("resp_asid", walk_resp_asid_o, asid);
        check("resp_vpn", walk_resp_vpn_o, vpn);
        check("resp_pte", walk_resp_pte_o, pte);
        check("resp_level", walk_resp_level_o, lvl);
        check("resp_pf", walk_resp_page_fault_o, pf);
        check("resp_af", walk_resp_access_fault_o, af);
        check("rdy_resp", walk_req_rdy_o, 0);
        check("mem_vld_resp", ptw_mem_req_vld_o, 0);
        if (exp_reqs >= 0) check("dir_nreq", nreq, exp_reqs);
        if (exp_pf >= 0) check("dir_pf", walk_resp_page_fault_o, exp_pf);
        if (exp_af >= 0) check("dir_af", walk_resp_access_fault_o, exp_af);
        @(negedge clk);
        walk_req_vld_i = 1'b0;
        check("resp_vld_pulse", walk_resp_vld_o, 0);
        check("rdy_after", walk_req_rdy_o, 1);
        check("busy_after", busy_o, 0);
        check("resp_tid_hold", walk_resp_trans_id_o, tid);
        check("resp_pte_hold", walk_resp_pte_o, pte);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; walk_req_vld_i = 1'b0; walk_req_trans_id_i = '0; walk_req_asid_i = '0;
        walk_req_vpn_i = '0; walk_req_access_type_i = '0; satp_ppn_i = '0;
        ptw_mem_req_rdy_i = 1'b0; ptw_mem_resp_vld_i = 1'b0; ptw_mem_resp_data_i = '0;
        ptw_mem_resp_err_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", walk_req_rdy_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_mem_vld", ptw_mem_req_vld_o, 0);
        check("rst_mem_addr", ptw_mem_req_addr_o, 0);
        check("rst_resp_vld", walk_resp_vld_o, 0);
        check("rst_resp_pte", walk_resp_pte_o, 0);
        check("rst_resp_flt", {walk_resp_page_fault_o, walk_resp_access_fault_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 4 KiB success through three levels
        hold_cycles = 0;
        forced_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_00CF};
        forced_err = '{0, 0, 0};
        run_walk(3'd5, 16'h1234, 27'h0040203, 2'd0, 44'h80000, 3, 0, 0);
        // 1 GiB superpage, aligned then misaligned
        forced_pte = '{64'h1000_00CF}; forced_err = '{0};
        run_walk(3'd1, 16'h0001, 27'h0040203, 2'd2, 44'h80000, 1, 0, 0);
        forced_pte = '{64'h1000_04CF}; forced_err = '{0};
        run_walk(3'd2, 16'h0002, 27'h0040203, 2'd0, 44'h80000, 1, 1, 0);
        // Store to clean leaf, V=0 at level 1, non-leaf at level 0
        forced_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_004F}; forced_err = '{0, 0, 0};
        run_walk(3'd3, 16'h0003, 27'h0040203, 2'd1, 44'h80000, 3, 1, 0);
        forced_pte = '{64'h2000_0401, 64'h0}; forced_err = '{0, 0};
        run_walk(3'd4, 16'h0004, 27'h0040203, 2'd0, 44'h80000, 2, 1, 0);
        forced_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_0C01}; forced_err = '{0, 0, 0};
        run_walk(3'd6, 16'h0006, 27'h0040203, 2'd0, 44'h80000, 3, 1, 0);
        // Bus error on the second read
        forced_pte = '{64'h2000_0401, 64'h2000_0801}; forced_err = '{0, 1};
        run_walk(3'd7, 16'h0007, 27'h0040203, 2'd0, 44'h80000, 2, 0, 1);
        // Memory request held off for five cycles
        hold_cycles = 5;
        forced_pte = '{64'h2000_0401, 64'h2000_0801, 64'h2000_00CF}; forced_err = '{0, 0, 0};
        run_walk(3'd0, 16'hBEEF, 27'h0040203, 2'd2, 44'h80000, 3, 0, 0);
        hold_cycles = -1;

        // Reset while waiting for read data; the late response must be dropped
        walk_req_vld_i = 1'b1; walk_req_trans_id_i = 3'd2; walk_req_vpn_i = 27'h0040203;
        walk_req_access_type_i = 2'd0; satp_ppn_i = 44'h80000;
        @(negedge clk);
        walk_req_vld_i = 1'b0; ptw_mem_req_rdy_i = 1'b1;
        @(negedge clk);
        ptw_mem_req_rdy_i = 1'b0;
        check("rst_mid_busy", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rdy", walk_req_rdy_o, 1);
        check("rst_mid_busy0", busy_o, 0);
        ptw_mem_resp_vld_i = 1'b1; ptw_mem_resp_data_i = 64'h2000_00CF;
        @(negedge clk);
        ptw_mem_resp_vld_i = 1'b0;
        check("stale_resp_vld", walk_resp_vld_o, 0);
        check("stale_rdy", walk_req_rdy_o, 1);
        check("stale_busy", busy_o, 0);
        check("stale_mem_vld", ptw_mem_req_vld_o, 0);
        @(negedge clk);
        check("stale_resp_vld2", walk_resp_vld_o, 0);

        // Random walks
        for (int i = 0; i < 250; i++) begin
            run_walk(3'($urandom()), 16'($urandom()), 27'($urandom()),
                     2'($urandom_range(0, 3)), 44'({$urandom(), $urandom()}), -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
